// File: rtl/multi_line_buffer_if.sv
// Pixel-in / column-out bundle for the multi-line buffer; the pixel source drives through
// master and the buffer uses slave. Single-cycle latency; no backpressure path.
interface multi_line_buffer_if #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int NUM_LINES = 3
);
    localparam int X_W   = $clog2(IMG_W);
    localparam int Y_W   = $clog2(IMG_H);
    localparam int COL_W = NUM_LINES * DATA_W;

    logic              we_i;
    logic              clr_i;
    logic [DATA_W-1:0] data_i;
    logic [COL_W-1:0]  col_o;
    logic [X_W-1:0]    x_o;
    logic [Y_W-1:0]    y_o;
    logic              valid_o;
    logic              line_done_o;
    logic              done_o;

    modport master (
        output we_i, clr_i, data_i,
        input  col_o, x_o, y_o, valid_o, line_done_o, done_o
    );

    modport slave (
        input  we_i, clr_i, data_i,
        output col_o, x_o, y_o, valid_o, line_done_o, done_o
    );
endinterface

// File: rtl/multi_line_buffer.sv
// Circular line memories emitting a NUM_LINES-high pixel column per accepted pixel.
// 1-cycle latency; no backpressure, one pixel per cycle.
module multi_line_buffer #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int NUM_LINES = 3
) (
    input  logic               clk,
    input  logic               rst,
    multi_line_buffer_if.slave bus
);
    localparam int X_W     = $clog2(IMG_W);
    localparam int Y_W     = $clog2(IMG_H);
    localparam int COL_W   = NUM_LINES * DATA_W;
    localparam int NUM_MEM = NUM_LINES - 1;

    // mem_q[0] holds the previous line, mem_q[NUM_MEM-1] the oldest
    logic [DATA_W-1:0] mem_q [NUM_MEM][IMG_W];
    logic [DATA_W-1:0] rd_dat [NUM_MEM];

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [X_W-1:0]   x_out_q, x_out_d;
    logic [Y_W-1:0]   y_out_q, y_out_d;
    logic             valid_q, valid_d;
    logic             line_done_q, line_done_d;
    logic             done_q, done_d;

    logic accept;
    logic last_x;
    logic last_y;

    assign accept = bus.we_i && !bus.clr_i;
    assign last_x = (x_q == X_W'(IMG_W - 1));
    assign last_y = (y_q == Y_W'(IMG_H - 1));

    always_comb begin
        for (int k = 0; k < NUM_MEM; k++) begin
            rd_dat[k] = mem_q[k][x_q];
        end
    end

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        col_d       = col_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        valid_d     = 1'b0;
        line_done_d = 1'b0;
        done_d      = 1'b0;
        if (bus.clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (bus.we_i) begin
            col_d[DATA_W-1:0] = bus.data_i;
            for (int k = 0; k < NUM_MEM; k++) begin
                col_d[(k+1)*DATA_W +: DATA_W] = rd_dat[k];
            end
            x_out_d = x_q;
            y_out_d = y_q;
            // Stale rows left over from the previous frame are masked here
            valid_d = (y_q >= Y_W'(NUM_LINES - 1));
            if (last_x) begin
                x_d         = '0;
                line_done_d = 1'b1;
                if (last_y) begin
                    y_d    = '0;
                    done_d = 1'b1;
                end else begin
                    y_d = y_q + Y_W'(1);
                end
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q         <= '0;
            y_q         <= '0;
            col_q       <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            valid_q     <= 1'b0;
            line_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            col_q       <= col_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            valid_q     <= valid_d;
            line_done_q <= line_done_d;
            done_q      <= done_d;
        end
    end

    // Read-before-write: each line shifts one memory deeper at the same address
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[0][x_q] <= bus.data_i;
            for (int k = 1; k < NUM_MEM; k++) begin
                mem_q[k][x_q] <= rd_dat[k-1];
            end
        end
    end

    assign bus.col_o       = col_q;
    assign bus.x_o         = x_out_q;
    assign bus.y_o         = y_out_q;
    assign bus.valid_o     = valid_q;
    assign bus.line_done_o = line_done_q;
    assign bus.done_o      = done_q;
endmodule
